amp_preprocessor_seq: RTL

Parametrised, time-multiplexed successor to the combinational amplitude pre-filter. It takes one frame of BIN_QTY fixed-point note amplitudes through a ready/valid handshake and computes a relative threshold, threshold = (sum of amplitudes × floor). A runtime floor value sets the threshold, replacing a compile-time constant. LANES bins are processed per cycle, which trades latency for area. It sits between the note-amplitude source and the visualizer datapath.

---
 rtl/amp_preprocessor_seq_if.sv | 32 +++
 rtl/amp_preprocessor_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/amp_preprocessor_seq_if.sv
// Frame handshake between the note-amplitude source, the amplitude
// pre-filter and the visualizer datapath.
interface amp_preprocessor_seq_if #(
    parameter int unsigned W       = 5,
    parameter int unsigned D       = 11,
    parameter int unsigned BIN_QTY = 12
);
    localparam int unsigned AW = W + D;
    localparam int unsigned SW = AW + $clog2(BIN_QTY);

    logic                       in_valid;
    logic                       in_ready;
    logic [BIN_QTY-1:0][AW-1:0] amps_i;
    logic [D-1:0]               floor_i;
    logic                       sub_en_i;
    logic                       out_valid;
    logic                       out_ready;
    logic [BIN_QTY-1:0][AW-1:0] amps_reduced_o;
    logic [BIN_QTY-1:0][AW-1:0] amps_fast_o;
    logic [SW-1:0]              sum_new_o;
    logic [SW-1:0]              threshold_o;

    modport slave (
        input  in_valid, amps_i, floor_i, sub_en_i, out_ready,
        output in_ready, out_valid, amps_reduced_o, amps_fast_o, sum_new_o, threshold_o
    );

    modport master (
        output in_valid, amps_i, floor_i, sub_en_i, out_ready,
        input  in_ready, out_valid, amps_reduced_o, amps_fast_o, sum_new_o, threshold_o
    );
endinterface

// File: rtl/amp_preprocessor_seq.sv
// Time-multiplexed amplitude pre-filter: sums a frame, derives a relative
// threshold from a runtime floor fraction, then gates/reduces LANES bins per cycle.
module amp_preprocessor_seq #(
    parameter int unsigned W       = 5,
    parameter int unsigned D       = 11,
    parameter int unsigned BIN_QTY = 12,
    parameter int unsigned LANES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    amp_preprocessor_seq_if.slave bus
);
    localparam int unsigned AW  = W + D;
    localparam int unsigned SW  = AW + $clog2(BIN_QTY);
    localparam int unsigned PW  = SW + D;
    localparam int unsigned P   = BIN_QTY / LANES;
    localparam int unsigned IW  = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned LSH = LANES * AW;
    localparam int unsigned TSH = (BIN_QTY - LANES) * AW;

    if ((BIN_QTY % LANES) != 0) begin : g_lanes_check
        $error("LANES must divide BIN_QTY");
    end

    typedef logic [BIN_QTY-1:0][AW-1:0] bins_t;
    typedef enum logic [2:0] {IDLE, SUM, THRESH, FILTER, DONE} state_t;

    state_t          state_q, state_n;
    bins_t           amps_q, red_q, fast_q;
    bins_t           amps_rot, grp_red, grp_fast;
    logic [D-1:0]    floor_q;
    logic            sub_en_q;
    logic [SW-1:0]   sum_q, sum_new_q, thr_q;
    logic [SW-1:0]   grp_sum, grp_red_sum;
    logic [PW-1:0]   prod;
    logic [IW-1:0]   idx_q;
    logic            last_grp;
    logic            in_ready_q, out_valid_q;

    // Latched bins rotate by one lane group per step; the current group is always bins [LANES-1:0].
    assign amps_rot = (amps_q >> LSH) | (amps_q << TSH);
    assign last_grp = (idx_q == IW'(P - 1));
    assign prod     = PW'(sum_q) * PW'(floor_q);

    // Lane-group arithmetic shared by SUM and FILTER.
    always_comb begin
        grp_sum     = '0;
        grp_red     = '0;
        grp_fast    = '0;
        grp_red_sum = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            grp_sum = grp_sum + SW'(amps_q[l]);
            if (SW'(amps_q[l]) >= thr_q) begin
                grp_fast[l] = amps_q[l];
                grp_red[l]  = sub_en_q ? (amps_q[l] - AW'(thr_q)) : amps_q[l];
            end
            grp_red_sum = grp_red_sum + SW'(grp_red[l]);
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_n = SUM;
            SUM:     if (last_grp) state_n = THRESH;
            THRESH:  state_n = FILTER;
            FILTER:  if (last_grp) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
        end
    end

    // Datapath; result arrays fill by shifting each new lane group in from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            amps_q    <= '0;
            red_q     <= '0;
            fast_q    <= '0;
            floor_q   <= '0;
            sub_en_q  <= 1'b0;
            sum_q     <= '0;
            sum_new_q <= '0;
            thr_q     <= '0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        amps_q    <= bus.amps_i;
                        floor_q   <= bus.floor_i;
                        sub_en_q  <= bus.sub_en_i;
                        sum_q     <= '0;
                        sum_new_q <= '0;
                        idx_q     <= '0;
                    end
                end
                SUM: begin
                    sum_q  <= sum_q + grp_sum;
                    amps_q <= amps_rot;
                    idx_q  <= last_grp ? '0 : idx_q + IW'(1);
                end
                THRESH: begin
                    thr_q <= prod[PW-1:D];
                end
                FILTER: begin
                    red_q     <= (red_q >> LSH) | (grp_red << TSH);
                    fast_q    <= (fast_q >> LSH) | (grp_fast << TSH);
                    sum_new_q <= sum_new_q + grp_red_sum;
                    amps_q    <= amps_rot;
                    idx_q     <= last_grp ? '0 : idx_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.amps_reduced_o = red_q;
    assign bus.amps_fast_o    = fast_q;
    assign bus.sum_new_o      = sum_new_q;
    assign bus.threshold_o    = thr_q;
endmodule
